// File: rtl/dma_arb_pkg.sv
// rtl/dma_arb_pkg.sv - shared types and helpers for the DMA packet arbiter
// Contents: arbiter FSM state encoding, default packet beat limit, and a
// ceil-log2 helper used to size grant indices and beat counters.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } arb_state_e;

  localparam int C_MAX_BEATS_DEFAULT = 50;

  // Bits needed to index 'value' distinct items; never less than 1.
  function automatic int log2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_grant_select.sv
// rtl/rr_grant_select.sv - combinational round-robin request selector
// Ports:
//   req        in   N   request vector, one bit per requester
//   last_grant in   GW  index granted most recently
//   valid      out  1   at least one request is pending
//   grant      out  GW  first requester found searching upward from last_grant+1
module rr_grant_select
  import dma_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = log2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last_grant,
  output logic          valid,
  output logic [GW-1:0] grant
);

  int            pos;
  logic [GW-1:0] pos_w;

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_grant is the one left in 'grant' when the loop ends.
  always_comb begin
    valid = |req;
    grant = '0;
    pos   = 0;
    pos_w = '0;
    for (int i = N; i >= 1; i--) begin
      pos = int'(last_grant) + i;
      if (pos >= N) pos = pos - N;
      pos_w = GW'(pos);
      if (req[pos_w]) grant = pos_w;
    end
  end

endmodule

// File: rtl/dma_pkt_arbiter.sv
// rtl/dma_pkt_arbiter.sv - packet-granular round-robin AXI4-Stream arbiter with length limit
// Ports:
//   axi_aclk/axi_reset          clock, synchronous active-high reset
//   s_axis_t{data,strb,user}    per-port stream payload, port i at slice i
//   s_axis_t{valid,ready,last}  per-port handshake and packet end
//   m_axis_t*                   single merged output stream
//   grant                       index of the port currently owning the output
//   trunc_err                   one-cycle pulse, bit = port whose packet was truncated
module dma_pkt_arbiter
  import dma_arb_pkg::*;
#(
  parameter  int C_AXIS_DATA_WIDTH  = 256,
  parameter  int C_AXIS_TUSER_WIDTH = 128,
  parameter  int C_NUM_PORTS        = 4,
  parameter  int C_MAX_BEATS        = C_MAX_BEATS_DEFAULT,
  localparam int GW                 = log2(C_NUM_PORTS),
  localparam int CW                 = log2(C_MAX_BEATS + 1)
) (
  input  logic                                      axi_aclk,
  input  logic                                      axi_reset,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [C_NUM_PORTS-1:0]                    s_axis_tvalid,
  output logic [C_NUM_PORTS-1:0]                    s_axis_tready,
  input  logic [C_NUM_PORTS-1:0]                    s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]              m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]            m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]             m_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  output logic [GW-1:0]                             grant,
  output logic [C_NUM_PORTS-1:0]                    trunc_err
);

  localparam int D = C_AXIS_DATA_WIDTH;
  localparam int S = C_AXIS_DATA_WIDTH / 8;
  localparam int U = C_AXIS_TUSER_WIDTH;

  arb_state_e    state;
  logic [GW-1:0] last_grant;
  logic [CW-1:0] beat_cnt;
  logic          sel_valid;
  logic [GW-1:0] sel_grant;
  logic          g_valid;
  logic          g_last;
  logic          at_limit;
  logic          beat_acc;

  rr_grant_select #(
    .N  (C_NUM_PORTS),
    .GW (GW)
  ) u_sel (
    .req        (s_axis_tvalid),
    .last_grant (last_grant),
    .valid      (sel_valid),
    .grant      (sel_grant)
  );

  assign g_valid  = s_axis_tvalid[grant];
  assign g_last   = s_axis_tlast[grant];
  // The beat about to be accepted is the last one allowed in a packet.
  assign at_limit = (beat_cnt == CW'(C_MAX_BEATS - 1));

  // Payload is a pure mux; only the handshake is gated by state.
  assign m_axis_tdata  = s_axis_tdata[int'(grant)*D +: D];
  assign m_axis_tstrb  = s_axis_tstrb[int'(grant)*S +: S];
  assign m_axis_tuser  = s_axis_tuser[int'(grant)*U +: U];
  assign m_axis_tvalid = (state == ST_SEND) && g_valid;
  assign m_axis_tlast  = (state == ST_SEND) && (g_last || at_limit);
  assign beat_acc      = m_axis_tvalid && m_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    case (state)
      ST_SEND: s_axis_tready[grant] = m_axis_tready;
      ST_DROP: s_axis_tready[grant] = 1'b1;
      default: s_axis_tready = '0;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= GW'(C_NUM_PORTS - 1);
      beat_cnt   <= '0;
      trunc_err  <= '0;
    end else begin
      trunc_err <= '0;
      case (state)
        ST_IDLE: begin
          if (sel_valid) begin
            grant      <= sel_grant;
            last_grant <= sel_grant;
            beat_cnt   <= '0;
            state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (beat_acc) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (g_last) begin
              state <= ST_IDLE;
            end else if (at_limit) begin
              // Forced tlast went out on this beat; swallow the rest.
              trunc_err[grant] <= 1'b1;
              state            <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (g_valid && g_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_pkt_arbiter.sv
// tb/tb_dma_pkt_arbiter.sv - directed self-checking bench for dma_pkt_arbiter
module tb_dma_pkt_arbiter;

  localparam int N  = 4;
  localparam int D  = 256;
  localparam int U  = 128;
  localparam int MB = 50;

  logic                 clk = 1'b0;
  logic                 axi_reset;
  logic [N*D-1:0]       s_axis_tdata;
  logic [N*D/8-1:0]     s_axis_tstrb;
  logic [N*U-1:0]       s_axis_tuser;
  logic [N-1:0]         s_axis_tvalid;
  logic [N-1:0]         s_axis_tready;
  logic [N-1:0]         s_axis_tlast;
  logic [D-1:0]         m_axis_tdata;
  logic [D/8-1:0]       m_axis_tstrb;
  logic [U-1:0]         m_axis_tuser;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic                 m_axis_tlast;
  logic [1:0]           grant;
  logic [N-1:0]         trunc_err;

  always #5 clk = ~clk;

  dma_pkt_arbiter #(
    .C_AXIS_DATA_WIDTH  (D),
    .C_AXIS_TUSER_WIDTH (U),
    .C_NUM_PORTS        (N),
    .C_MAX_BEATS        (MB)
  ) dut (
    .axi_aclk      (clk),
    .axi_reset     (axi_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .grant         (grant),
    .trunc_err     (trunc_err)
  );

  typedef struct {
    int cyc;
    int port;
    int idx;
    bit last;
  } beat_t;

  beat_t out_q[$];
  int    rem[N];
  int    idx[N];
  int    npkt[N];
  int    plen[N];
  int    cyc;
  int    trunc_cnt;
  int    trunc_cyc;
  int    trunc_val;
  int    drop_cnt;
  int    n_vec;
  int    n_miss;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i]       = (rem[i] != 0);
      s_axis_tlast[i]        = (rem[i] == 1);
      s_axis_tdata[i*D +: D] = D'({8'(i), 16'(idx[i])});
      s_axis_tuser[i*U +: U] = U'({8'(i), 16'(idx[i]), 8'hA5});
    end
    s_axis_tstrb = '1;
  endtask

  // Sample handshakes on settled pre-edge values, clock, then advance sources.
  task automatic step();
    logic [N-1:0] acc;
    beat_t        b;
    acc = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      b.cyc  = cyc;
      b.port = int'(m_axis_tdata[23:16]);
      b.idx  = int'(m_axis_tdata[15:0]);
      b.last = m_axis_tlast;
      out_q.push_back(b);
    end
    if (trunc_err != '0) begin
      trunc_cnt++;
      trunc_val = int'(trunc_err);
      trunc_cyc = cyc;
    end
    if (!m_axis_tvalid) drop_cnt += $countones(acc);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        idx[i]++;
        rem[i]--;
        if (rem[i] == 0 && npkt[i] > 0) begin
          npkt[i]--;
          rem[i] = plen[i];
          idx[i] = 0;
        end
      end
    end
    drive();
    #1;
  endtask

  function automatic int busy();
    int b;
    b = 0;
    for (int i = 0; i < N; i++) if (rem[i] != 0) b = 1;
    return b;
  endfunction

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (busy() != 0 && k < 300) begin
      step();
      k++;
    end
    chk({tag, "_drained"}, 64'(busy()), 64'd0);
  endtask

  task automatic do_reset();
    axi_reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      idx[i]  = 0;
      npkt[i] = 0;
      plen[i] = 0;
    end
    drive();
    step();
    step();
    axi_reset = 1'b0;
    out_q.delete();
    trunc_cnt = 0;
    trunc_cyc = -1;
    trunc_val = 0;
    drop_cnt  = 0;
  endtask

  task automatic check_beats(input string tag, input int first, input int port, input int n);
    for (int k = 0; k < n; k++) begin
      if (first + k < out_q.size()) begin
        chk({tag, "_port"}, 64'(out_q[first+k].port), 64'(port));
        chk({tag, "_idx"},  64'(out_q[first+k].idx),  64'(k));
        chk({tag, "_last"}, 64'(out_q[first+k].last), 64'(k == n - 1));
      end
    end
  endtask

  logic bp_pat [4];
  int   exp_fair [6];

  initial begin
    n_vec = 0;
    n_miss = 0;
    cyc = 0;
    m_axis_tready = 1'b1;
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_fair = '{0, 1, 2, 3, 0, 1};

    // Reset state
    do_reset();
    chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_sready", 64'(s_axis_tready), 64'd0);
    chk("rst_grant",  64'(grant),         64'd0);
    chk("rst_trunc",  64'(trunc_err),     64'd0);

    // Single request: port 2, 3 beats
    rem[2] = 3;
    drive();
    #1;
    chk("single_idle_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("single_idle_sready", 64'(s_axis_tready), 64'd0);
    step();
    chk("single_grant",  64'(grant),         64'd2);
    chk("single_mvalid", 64'(m_axis_tvalid), 64'd1);
    chk("single_sready", 64'(s_axis_tready), 64'h4);
    chk("single_tuser",  64'(m_axis_tuser[31:0]), 64'h020000A5);
    chk("single_tstrb",  64'(m_axis_tstrb), 64'hFFFFFFFF);
    drain("single");
    chk("single_nbeats", 64'(out_q.size()), 64'd3);
    check_beats("single", 0, 2, 3);
    chk("single_end_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("single_end_sready", 64'(s_axis_tready), 64'd0);

    // Fairness: all ports request 2-beat packets, ports 0/1 have a second one
    do_reset();
    for (int i = 0; i < N; i++) begin
      rem[i]  = 2;
      plen[i] = 2;
    end
    npkt[0] = 1;
    npkt[1] = 1;
    drive();
    drain("fair");
    chk("fair_nbeats", 64'(out_q.size()), 64'd12);
    for (int j = 0; j < 6; j++) begin
      check_beats($sformatf("fair_p%0d", j), 2 * j, exp_fair[j], 2);
      if (j < 5 && 2 * j + 2 < out_q.size())
        chk($sformatf("fair_gap%0d", j), 64'(out_q[2*j+2].cyc - out_q[2*j].cyc), 64'd3);
    end

    // Backpressure: port 1, 5 beats, downstream ready 1,0,0,1,...
    do_reset();
    rem[1] = 5;
    drive();
    for (int k = 0; k < 40 && busy() != 0; k++) begin
      m_axis_tready = bp_pat[k % 4];
      #1;
      if (m_axis_tvalid)
        chk("bp_mirror", 64'(s_axis_tready), 64'({2'b00, m_axis_tready, 1'b0}));
      step();
    end
    chk("bp_drained", 64'(busy()), 64'd0);
    m_axis_tready = 1'b1;
    chk("bp_nbeats", 64'(out_q.size()), 64'd5);
    check_beats("bp", 0, 1, 5);

    // Truncation: port 3 sends 60 beats, ports 0/1 join later
    do_reset();
    rem[3] = 60;
    drive();
    for (int k = 0; k < 100 && out_q.size() < 10; k++) step();
    rem[0] = 1;
    rem[1] = 1;
    drive();
    #1;
    drain("trunc");
    chk("trunc_nbeats", 64'(out_q.size()), 64'd52);
    check_beats("trunc", 0, 3, MB);
    chk("trunc_pulses", 64'(trunc_cnt), 64'd1);
    chk("trunc_value",  64'(trunc_val), 64'h8);
    if (out_q.size() >= MB)
      chk("trunc_when", 64'(trunc_cyc), 64'(out_q[MB-1].cyc + 1));
    chk("trunc_dropped", 64'(drop_cnt), 64'd10);
    check_beats("trunc_next0", MB, 0, 1);
    check_beats("trunc_next1", MB + 1, 1, 1);

    // Exact limit: 50 beats with tlast on beat 50
    do_reset();
    rem[2] = MB;
    drive();
    drain("exact");
    chk("exact_nbeats", 64'(out_q.size()), 64'(MB));
    check_beats("exact", 0, 2, MB);
    chk("exact_trunc",  64'(trunc_cnt), 64'd0);
    chk("exact_sready", 64'(s_axis_tready), 64'd0);
    chk("exact_mvalid", 64'(m_axis_tvalid), 64'd0);

    // Reset mid-packet at beat 7 of port 0
    do_reset();
    rem[0] = 20;
    drive();
    for (int k = 0; k < 100 && out_q.size() < 6; k++) step();
    chk("mid_beat7_idx", 64'(m_axis_tdata[15:0]), 64'd6);
    axi_reset = 1'b1;
    step();
    chk("mid_rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("mid_rst_sready", 64'(s_axis_tready), 64'd0);
    chk("mid_rst_grant",  64'(grant),         64'd0);
    rem[0] = 2;
    idx[0] = 0;
    rem[1] = 2;
    drive();
    axi_reset = 1'b0;
    out_q.delete();
    #1;
    drain("mid");
    chk("mid_nbeats", 64'(out_q.size()), 64'd4);
    check_beats("mid_first", 0, 0, 2);
    check_beats("mid_second", 2, 1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
